regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised successor to the integer register file. It provides NUM_RD combinational read ports, one synchronous write port, and a per-register scoreboard of pending writes. An optional write-to-read bypass is included, along with a sequential post-reset clear sequencer. It sits in the decode/writeback path of the core. The hazard unit uses r_busy to stall issue.

Parameters:
XLEN, 32, data width per register
AW, 5, register address width; NREGS = 2**AW
NUM_RD, 2, number of read ports (>=1)
BYPASS, 1, 1: read of a register being written this cycle returns w_reg_val; 0: returns stored value
CLR_ON_RESET, 1, 1: zero all registers after reset via clear sequencer; 0: start READY immediately, contents undefined

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
r_reg_name  in  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW]
r_reg_val  out  NUM_RD*XLEN  read data; port i at [i*XLEN +: XLEN]
r_busy  out  NUM_RD  port i register has an outstanding write
w_enable  in  1  write strobe
w_reg_name  in  AW  write address
w_reg_val  in  XLEN  write data
alloc_en  in  1  mark alloc_reg_name pending (instruction issued with that rd)
alloc_reg_name  in  AW  register to mark busy
init_done  out  1  1 when in READY state

Behaviour:
- Reset (rst_n low, asynchronous):
  - all busy bits cleared.
  - FSM goes to CLEAR if CLR_ON_RESET=1, else READY.
  - clear index set to 1; init_done = 0 (1 if CLR_ON_RESET=0).
  - Register contents are not otherwise touched.
- FSM CLEAR:
  - each rising edge writes 0 to regs[idx], then idx increments.
  - after the edge writing regs[NREGS-1], FSM goes to READY.
  - CLEAR lasts exactly NREGS-1 cycles; init_done rises after the (NREGS-1)th edge following rst_n release.
  - In CLEAR: w_enable and alloc_en are ignored, all r_reg_val = 0, all r_busy = 0.
- FSM READY: terminal until the next reset. Reset mid-CLEAR restarts the sequence from idx 1.
- x0:
  - regs[0] is not stored; reads of address 0 always return 0 with busy 0.
  - writes and allocs to address 0 are ignored.
- Write: in READY, when w_enable and w_reg_name != 0, regs[w_reg_name] <= w_reg_val on the rising edge (posedge, not negedge).
- Read: combinational, zero latency, for each port i independently.
  - Port i returns 0 if its address is 0.
  - Else, if BYPASS=1 and w_enable and w_reg_name == r_reg_name[i], it returns w_reg_val.
  - Else it returns regs[addr].
- Scoreboard:
  - alloc_en with name != 0 sets busy[name] on the edge.
  - w_enable with name != 0 clears busy[w_reg_name] on the edge.
  - Alloc and write to the same register in the same cycle: busy stays 1 (newer producer wins); the data write still happens.
  - A write to a non-busy register is legal and leaves busy 0.
- r_busy[i] = busy[r_reg_name[i]], except:
  - when BYPASS=1 and a same-cycle write targets that register, r_busy[i] = 0.
  - the same-cycle alloc is not visible until the next cycle.
- All ports may read the same address simultaneously with identical results.

Test Plan:
- Clear sequence:
  - Stimulus: CLR_ON_RESET=1, AW=5; release rst_n, w_enable=1 with x5=0xDEADBEEF during CLEAR.
  - Required: init_done rises exactly 31 cycles after release, r_reg_val = 0 throughout, and x5 reads 0 afterwards (write ignored).
- Basic read/write:
  - Stimulus: write x3=0x12345678, then x31=0xFFFFFFFF.
  - Required: next cycle, ports 0/1 reading x3/x31 return 0x12345678/0xFFFFFFFF.
  - Stimulus: write x0=0xAAAA5555.
  - Required: x0 reads 0.
- Bypass:
  - Stimulus: BYPASS=1; same cycle w_enable, x7=0xCAFEF00D, both ports reading x7.
  - Required: both return 0xCAFEF00D combinationally.
  - Stimulus: BYPASS=0, same setup.
  - Required: old value in that cycle, 0xCAFEF00D next cycle.
- Scoreboard:
  - Stimulus: alloc x9; next cycle read x9.
  - Required: r_busy = 1.
  - Stimulus: write x9 (BYPASS=1).
  - Required: r_busy = 0 in the write cycle and after.
  - Stimulus: alloc x0.
  - Required: x0 busy stays 0.
- Simultaneous alloc + write:
  - Stimulus: x4 busy; same cycle alloc x4 and write x4=0x11.
  - Required: next cycle x4 reads 0x11 and r_busy = 1.
- Reset mid-operation:
  - Stimulus: assert rst_n low asynchronously (between edges) with x9 busy, mid-READY.
  - Required: r_busy drops to 0 immediately and init_done drops to 0 immediately.
  - Required: a full 31-cycle clear reruns, then all registers read 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb
// Integer register file with NUM_RD combinational read ports, one synchronous
// write port, a per-register pending-write scoreboard, an optional same-cycle
// write-to-read bypass and a post-reset clear sequencer.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   r_reg_name     read addresses, port i at [i*AW +: AW]
//   r_reg_val      read data, port i at [i*XLEN +: XLEN]
//   r_busy         per port: addressed register has an outstanding write
//   w_enable       write strobe
//   w_reg_name     write address
//   w_reg_val      write data
//   alloc_en       mark alloc_reg_name as pending
//   alloc_reg_name register to mark busy
//   init_done      high once the clear sequence has finished (READY)
module regfile_sb #(
  parameter int XLEN         = 32,
  parameter int AW           = 5,
  parameter int NUM_RD       = 2,
  parameter int BYPASS       = 1,
  parameter int CLR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   r_reg_name,
  output logic [NUM_RD*XLEN-1:0] r_reg_val,
  output logic [NUM_RD-1:0]      r_busy,
  input  logic                   w_enable,
  input  logic [AW-1:0]          w_reg_name,
  input  logic [XLEN-1:0]        w_reg_val,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_reg_name,
  output logic                   init_done
);

  localparam int NREGS   = 2 ** AW;
  localparam bit BYP_ON  = (BYPASS != 0);
  localparam bit CLR_ON  = (CLR_ON_RESET != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     idx_reg, idx_next;
  logic [NREGS-1:0]  busy_reg, busy_next;
  logic [XLEN-1:0]   regs_mem [NREGS];

  logic ready;
  logic w_fire;
  logic a_fire;

  assign ready     = (state_reg == ST_READY);
  assign init_done = ready;
  // x0 is hardwired: writes and allocs to it never take effect, and nothing
  // is accepted while the clear sequencer owns the array.
  assign w_fire    = ready && w_enable && (w_reg_name != '0);
  assign a_fire    = ready && alloc_en && (alloc_reg_name != '0);

  // Sequencer next state: walk idx from 1 up to NREGS-1, then go READY.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    if (state_reg == ST_CLEAR) begin
      idx_next = idx_reg + 1'b1;
      if (idx_reg == '1) begin
        state_next = ST_READY;
      end
    end
  end

  // Scoreboard: alloc is applied after the write-clear so that a same-cycle
  // alloc (newer producer) keeps the register busy.
  always_comb begin
    busy_next = busy_reg;
    if (w_fire) begin
      busy_next[w_reg_name] = 1'b0;
    end
    if (a_fire) begin
      busy_next[alloc_reg_name] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLR_ON ? ST_CLEAR : ST_READY;
      idx_reg   <= AW'(1);
      busy_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      busy_reg  <= busy_next;
    end
  end

  // Storage has no reset; contents are only touched by the clear sequencer
  // or by an accepted write. Gating on rst_n keeps a held reset from
  // repeatedly zeroing regs[1].
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!ready) begin
        regs_mem[idx_reg] <= '0;
      end else if (w_fire) begin
        regs_mem[w_reg_name] <= w_reg_val;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]   rd_addr;
      logic            rd_hit;
      logic [XLEN-1:0] rd_val_next;
      logic            rd_busy_next;

      assign rd_addr = r_reg_name[gi*AW +: AW];
      assign rd_hit  = BYP_ON && w_enable && (w_reg_name == rd_addr);

      always_comb begin
        rd_val_next  = '0;
        rd_busy_next = 1'b0;
        if (ready && (rd_addr != '0)) begin
          if (rd_hit) begin
            rd_val_next  = w_reg_val;
            rd_busy_next = 1'b0;
          end else begin
            rd_val_next  = regs_mem[rd_addr];
            rd_busy_next = busy_reg[rd_addr];
          end
        end
      end

      assign r_reg_val[gi*XLEN +: XLEN] = rd_val_next;
      assign r_busy[gi]                 = rd_busy_next;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [9:0]  r_reg_name;
  logic [63:0] r_val_b1, r_val_b0;
  logic [1:0]  r_busy_b1, r_busy_b0;
  logic        w_enable;
  logic [4:0]  w_reg_name;
  logic [31:0] w_reg_val;
  logic        alloc_en;
  logic [4:0]  alloc_reg_name;
  logic        init_done_b1, init_done_b0;

  int checks   = 0;
  int failures = 0;

  regfile_sb #(.XLEN(32), .AW(5), .NUM_RD(2), .BYPASS(1), .CLR_ON_RESET(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .r_reg_name(r_reg_name), .r_reg_val(r_val_b1),
    .r_busy(r_busy_b1), .w_enable(w_enable), .w_reg_name(w_reg_name),
    .w_reg_val(w_reg_val), .alloc_en(alloc_en), .alloc_reg_name(alloc_reg_name),
    .init_done(init_done_b1)
  );

  regfile_sb #(.XLEN(32), .AW(5), .NUM_RD(2), .BYPASS(0), .CLR_ON_RESET(1)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .r_reg_name(r_reg_name), .r_reg_val(r_val_b0),
    .r_busy(r_busy_b0), .w_enable(w_enable), .w_reg_name(w_reg_name),
    .w_reg_val(w_reg_val), .alloc_en(alloc_en), .alloc_reg_name(alloc_reg_name),
    .init_done(init_done_b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    r_reg_name = {a1, a0};
  endtask

  task automatic idle_inputs();
    w_enable = 1'b0; w_reg_name = '0; w_reg_val = '0;
    alloc_en = 1'b0; alloc_reg_name = '0;
  endtask

  // Counts edges from reset release until init_done; during CLEAR a write to
  // x5 and an alloc of x5 are driven and must be ignored, reads must be 0.
  task automatic run_clear(input string tag, output int n);
    int bad;
    n = 0;
    bad = 0;
    w_enable = 1'b1; w_reg_name = 5'd5; w_reg_val = 32'hDEADBEEF;
    alloc_en = 1'b1; alloc_reg_name = 5'd5;
    set_rd(5'd5, 5'd3);
    #1;
    while (!init_done_b1 && n < 100) begin
      if (r_val_b1 !== 64'd0 || r_val_b0 !== 64'd0 || r_busy_b1 !== 2'b00) bad++;
      step();
      n++;
    end
    idle_inputs();
    check_val({tag, "_clear_reads_zero"}, 32'(bad), 32'd0);
    check_val({tag, "_clear_cycles"}, 32'(n), 32'd31);
    check_val({tag, "_nobyp_init_done"}, {31'd0, init_done_b0}, 32'd1);
    $display("clear sequence %s done after %0d cycles", tag, n);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    idle_inputs();
    set_rd(5'd0, 5'd0);
    #22;
    check_val("rst_init_done", {31'd0, init_done_b1}, 32'd0);
    check_val("rst_busy", {30'd0, r_busy_b1}, 32'd0);

    // Release just after a rising edge so edge counting starts cleanly.
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_clear("first", n);

    // x5 must not have taken the write or alloc issued during CLEAR.
    set_rd(5'd5, 5'd5);
    #1;
    check_val("x5_after_clear", r_val_b1[31:0], 32'd0);
    check_val("x5_busy_after_clear", {31'd0, r_busy_b1[0]}, 32'd0);

    // Basic writes.
    step();
    w_enable = 1'b1; w_reg_name = 5'd3; w_reg_val = 32'h12345678;
    $display("write x3=12345678");
    step();
    w_reg_name = 5'd31; w_reg_val = 32'hFFFFFFFF;
    $display("write x31=ffffffff");
    step();
    idle_inputs();
    set_rd(5'd3, 5'd31);
    #1;
    check_val("rd_p0_x3", r_val_b1[31:0], 32'h12345678);
    check_val("rd_p1_x31", r_val_b1[63:32], 32'hFFFFFFFF);
    check_val("nobyp_p0_x3", r_val_b0[31:0], 32'h12345678);

    // Write to x0 is dropped, even on the bypass path.
    step();
    w_enable = 1'b1; w_reg_name = 5'd0; w_reg_val = 32'hAAAA5555;
    set_rd(5'd0, 5'd0);
    $display("write x0=aaaa5555");
    #1;
    check_val("x0_same_cycle", r_val_b1[31:0], 32'd0);
    step();
    idle_inputs();
    #1;
    check_val("x0_p0", r_val_b1[31:0], 32'd0);
    check_val("x0_p1", r_val_b1[63:32], 32'd0);

    // Bypass vs no bypass on x7.
    step();
    w_enable = 1'b1; w_reg_name = 5'd7; w_reg_val = 32'hCAFEF00D;
    set_rd(5'd7, 5'd7);
    $display("write x7=cafef00d with both ports reading x7");
    #1;
    check_val("byp_p0", r_val_b1[31:0], 32'hCAFEF00D);
    check_val("byp_p1", r_val_b1[63:32], 32'hCAFEF00D);
    check_val("nobyp_old_p0", r_val_b0[31:0], 32'd0);
    check_val("nobyp_old_p1", r_val_b0[63:32], 32'd0);
    step();
    idle_inputs();
    #1;
    check_val("nobyp_next_p0", r_val_b0[31:0], 32'hCAFEF00D);
    check_val("nobyp_next_p1", r_val_b0[63:32], 32'hCAFEF00D);

    // Scoreboard on x9.
    step();
    alloc_en = 1'b1; alloc_reg_name = 5'd9;
    set_rd(5'd9, 5'd0);
    $display("alloc x9");
    #1;
    check_val("alloc_same_cycle_busy", {31'd0, r_busy_b1[0]}, 32'd0);
    step();
    idle_inputs();
    #1;
    check_val("alloc_next_busy", {31'd0, r_busy_b1[0]}, 32'd1);
    check_val("alloc_next_busy_nobyp", {31'd0, r_busy_b0[0]}, 32'd1);
    step();
    w_enable = 1'b1; w_reg_name = 5'd9; w_reg_val = 32'h00000099;
    $display("write x9=00000099");
    #1;
    check_val("wr_cycle_busy_byp", {31'd0, r_busy_b1[0]}, 32'd0);
    check_val("wr_cycle_busy_nobyp", {31'd0, r_busy_b0[0]}, 32'd1);
    step();
    idle_inputs();
    #1;
    check_val("after_wr_busy", {31'd0, r_busy_b1[0]}, 32'd0);
    check_val("after_wr_val", r_val_b1[31:0], 32'h00000099);

    // Alloc of x0 is ignored.
    step();
    alloc_en = 1'b1; alloc_reg_name = 5'd0;
    set_rd(5'd9, 5'd0);
    $display("alloc x0");
    step();
    idle_inputs();
    #1;
    check_val("x0_alloc_busy", {31'd0, r_busy_b1[1]}, 32'd0);

    // Simultaneous alloc + write to x4: newer producer keeps it busy.
    step();
    alloc_en = 1'b1; alloc_reg_name = 5'd4;
    $display("alloc x4");
    step();
    w_enable = 1'b1; w_reg_name = 5'd4; w_reg_val = 32'h00000011;
    $display("alloc x4 and write x4=00000011");
    step();
    idle_inputs();
    set_rd(5'd4, 5'd4);
    #1;
    check_val("alloc_wr_val", r_val_b1[31:0], 32'h00000011);
    check_val("alloc_wr_busy", {31'd0, r_busy_b1[0]}, 32'd1);
    check_val("alloc_wr_busy_p1", {31'd0, r_busy_b1[1]}, 32'd1);

    // Asynchronous reset mid-READY with x9 busy.
    step();
    alloc_en = 1'b1; alloc_reg_name = 5'd9;
    step();
    idle_inputs();
    set_rd(5'd9, 5'd4);
    #1;
    check_val("pre_rst_busy_x9", {31'd0, r_busy_b1[0]}, 32'd1);
    #1;
    rst_n = 1'b0;
    $display("async reset asserted mid-cycle");
    #1;
    check_val("async_rst_busy", {30'd0, r_busy_b1}, 32'd0);
    check_val("async_rst_init_done", {31'd0, init_done_b1}, 32'd0);
    step();
    rst_n = 1'b1;
    run_clear("second", n);

    for (int a = 0; a < 32; a++) begin
      set_rd(a[4:0], a[4:0]);
      #1;
      check_val($sformatf("post_clear_x%0d", a), r_val_b1[31:0], 32'd0);
      check_val($sformatf("post_clear_nobyp_x%0d", a), r_val_b0[63:32], 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
